// File: rtl/kmac_msg_padder.sv
// KMAC message padder: masks strobed message words into the Keccak rate block, applies domain/final padding.
// Optional strobe/mode error checker enabled by defining KMAC_PAD_ERR_CHK_EN.
module kmac_msg_padder #(
  parameter int MsgWidth = 64,
  parameter int MaxRateW = 21
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic                        process_i,
  input  logic [3:0]                  clear_i,
  input  logic [1:0]                  mode_i,
  input  logic [2:0]                  strength_i,
  input  logic                        msg_valid_i,
  input  logic [MsgWidth-1:0]         msg_data_i,
  input  logic [MsgWidth/8-1:0]       msg_strb_i,
  output logic                        msg_ready_o,
  output logic                        keccak_valid_o,
  output logic [$clog2(MaxRateW)-1:0] keccak_addr_o,
  output logic [MsgWidth-1:0]         keccak_data_o,
  output logic                        keccak_run_o,
  input  logic                        keccak_done_i,
  output logic                        absorbed_o,
  output logic                        err_o
);

  localparam int AddrW = $clog2(MaxRateW);
  localparam logic [3:0] MuBi4True = 4'h6;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAbsorb  = 3'd1,
    StRunWait = 3'd2,
    StPad     = 3'd3,
    StPadEnd  = 3'd4,
    StPadRun  = 3'd5,
    StPadWait = 3'd6,
    StDone    = 3'd7
  } state_e;

  state_e           st_r;
  logic [AddrW-1:0] rate_r;
  logic [AddrW-1:0] word_cnt_r;
  logic [2:0]       off_r;
  logic [1:0]       mode_r;
  logic             partial_r;
  logic             proc_pend_r;
  logic             run_r;
  logic             absorbed_r;

  logic             clr_s;
  logic             accept_s;
  logic             full_s;
  logic             last_s;
  logic [2:0]       off_s;
  logic [63:0]      pad_data_s;

  function automatic logic [63:0] strb_mask(input logic [7:0] strb);
    logic [63:0] m;
    m = 64'd0;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

  // Only meaningful for partial strobes, so the 8-byte case wrapping to 0 is harmless.
  function automatic logic [2:0] strb_count(input logic [7:0] strb);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {2'b00, strb[i]};
    end
    return c;
  endfunction

  function automatic logic [AddrW-1:0] rate_words(input logic [2:0] strength);
    logic [AddrW-1:0] r;
    case (strength)
      3'd0:    r = AddrW'(21);
      3'd1:    r = AddrW'(18);
      3'd2:    r = AddrW'(17);
      3'd3:    r = AddrW'(13);
      3'd4:    r = AddrW'(9);
      default: r = AddrW'(17);
    endcase
    return r;
  endfunction

  function automatic logic [7:0] pad_byte(input logic [1:0] mode);
    logic [7:0] p;
    case (mode)
      2'd0:    p = 8'h06;
      2'd1:    p = 8'h1F;
      2'd2:    p = 8'h04;
      default: p = 8'h06;
    endcase
    return p;
  endfunction

  // Handshake, word write path and padding word generation.
  always_comb begin
    clr_s          = (clear_i == MuBi4True);
    msg_ready_o    = (st_r == StAbsorb) && !clr_s;
    accept_s       = msg_ready_o && msg_valid_i;
    full_s         = (msg_strb_i == 8'hFF);
    last_s         = (word_cnt_r == (rate_r - AddrW'(1)));
    off_s          = partial_r ? off_r : 3'd0;
    pad_data_s     = {56'd0, pad_byte(mode_r)} << {off_s, 3'b000};
    keccak_valid_o = 1'b0;
    keccak_addr_o  = {AddrW{1'b0}};
    keccak_data_o  = 64'd0;
    if (last_s) begin
      pad_data_s = pad_data_s | 64'h8000_0000_0000_0000;
    end else begin
      pad_data_s = pad_data_s;
    end
    case (st_r)
      StAbsorb: begin
        if (accept_s) begin
          keccak_valid_o = 1'b1;
          keccak_addr_o  = word_cnt_r;
          keccak_data_o  = msg_data_i & strb_mask(msg_strb_i);
        end else begin
          keccak_valid_o = 1'b0;
        end
      end
      StPad: begin
        if (!clr_s) begin
          keccak_valid_o = 1'b1;
          keccak_addr_o  = word_cnt_r;
          keccak_data_o  = pad_data_s;
        end else begin
          keccak_valid_o = 1'b0;
        end
      end
      StPadEnd: begin
        if (!clr_s) begin
          keccak_valid_o = 1'b1;
          keccak_addr_o  = rate_r - AddrW'(1);
          keccak_data_o  = 64'h8000_0000_0000_0000;
        end else begin
          keccak_valid_o = 1'b0;
        end
      end
      default: begin
        keccak_valid_o = 1'b0;
      end
    endcase
    keccak_run_o = run_r && !clr_s;
    absorbed_o   = absorbed_r;
  end

  // Main padder FSM with block counter, partial-word tracking and deferred process request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_r        <= StIdle;
      rate_r      <= AddrW'(17);
      word_cnt_r  <= {AddrW{1'b0}};
      off_r       <= 3'd0;
      mode_r      <= 2'd0;
      partial_r   <= 1'b0;
      proc_pend_r <= 1'b0;
      run_r       <= 1'b0;
      absorbed_r  <= 1'b0;
    end else if (clr_s) begin
      st_r        <= StIdle;
      word_cnt_r  <= {AddrW{1'b0}};
      off_r       <= 3'd0;
      partial_r   <= 1'b0;
      proc_pend_r <= 1'b0;
      run_r       <= 1'b0;
      absorbed_r  <= 1'b0;
    end else begin
      run_r      <= 1'b0;
      absorbed_r <= 1'b0;
      case (st_r)
        StIdle: begin
          if (start_i) begin
            st_r        <= StAbsorb;
            rate_r      <= rate_words(strength_i);
            mode_r      <= mode_i;
            word_cnt_r  <= {AddrW{1'b0}};
            off_r       <= 3'd0;
            partial_r   <= 1'b0;
            proc_pend_r <= 1'b0;
          end
        end
        StAbsorb: begin
          if (accept_s) begin
            if (full_s) begin
              if (last_s) begin
                word_cnt_r <= {AddrW{1'b0}};
                run_r      <= 1'b1;
                st_r       <= StRunWait;
              end else begin
                word_cnt_r <= word_cnt_r + AddrW'(1);
              end
            end else begin
              partial_r <= 1'b1;
              off_r     <= strb_count(msg_strb_i);
            end
            if (process_i) begin
              proc_pend_r <= 1'b1;
            end
          end else if (process_i || proc_pend_r) begin
            proc_pend_r <= 1'b0;
            st_r        <= StPad;
          end
        end
        StRunWait: begin
          if (process_i) begin
            proc_pend_r <= 1'b1;
          end
          if (keccak_done_i) begin
            st_r <= StAbsorb;
          end
        end
        StPad: begin
          st_r <= last_s ? StPadRun : StPadEnd;
        end
        StPadEnd: begin
          st_r <= StPadRun;
        end
        StPadRun: begin
          run_r <= 1'b1;
          st_r  <= StPadWait;
        end
        StPadWait: begin
          if (keccak_done_i) begin
            absorbed_r <= 1'b1;
            st_r       <= StDone;
          end
        end
        StDone: begin
          st_r <= StDone;
        end
        default: begin
          st_r <= StIdle;
        end
      endcase
    end
  end

`ifdef KMAC_PAD_ERR_CHK_EN
  logic err_r;
  logic err_s;

  // Flags malformed strobes, words after a partial word, and an illegal mode at start.
  always_comb begin
    err_s = 1'b0;
    if (accept_s) begin
      err_s = (msg_strb_i == 8'h00) ||
              ((msg_strb_i & (msg_strb_i + 8'h01)) != 8'h00) ||
              partial_r;
    end else begin
      err_s = 1'b0;
    end
    if ((st_r == StIdle) && start_i && !clr_s && (mode_i == 2'd3)) begin
      err_s = 1'b1;
    end else begin
      err_s = err_s;
    end
  end

  // One-cycle registered error pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_s;
    end
  end

  assign err_o = err_r;
`else
  assign err_o = 1'b0;
`endif

endmodule
